camera_cfg_seq: RTL

Register-configuration sequencer for the camera I2C write engine (`i2c_com`). After power-up it walks an external register table, issues one 32-bit write per entry, and handles inline delay entries. It checks the three ACK slots of every write and reports completion or error to the camera top level. It runs in the `clock_i2c` domain and is the only driver of the write engine's `start` and `i2c_data`.

---
 rtl/camera_cfg_pkg.sv | 37 +++
 rtl/camera_cfg_seq_chk.sv | 15 +
 rtl/camera_cfg_seq_wait_cnt.sv | 30 +++
 rtl/camera_cfg_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/camera_cfg_pkg.sv
// Shared constants and helpers for the camera register-configuration sequencer.
// The optional retry feature is built when CAMERA_CFG_RETRY_EN is defined.
package camera_cfg_pkg;

    typedef logic [2:0] cfg_state_t;

    localparam cfg_state_t ST_PWR_WAIT = 3'd0;
    localparam cfg_state_t ST_FETCH    = 3'd1;
    localparam cfg_state_t ST_LOAD     = 3'd2;
    localparam cfg_state_t ST_XFER     = 3'd3;
    localparam cfg_state_t ST_CHECK    = 3'd4;
    localparam cfg_state_t ST_DELAY    = 3'd5;
    localparam cfg_state_t ST_DONE     = 3'd6;

    localparam int unsigned DEV_MSB     = 32'd31;
    localparam int unsigned DEV_LSB     = 32'd24;
    localparam int unsigned DLY_MSB     = 32'd15;
    localparam logic [7:0]  DELAY_TAG   = 8'h00;
    localparam int unsigned PWR_DLY_DEF = 32'd1024;

    // A zero device address marks an inline delay entry rather than a bus write
    function automatic logic is_delay_entry(input logic [31:0] word);
        return (word[DEV_MSB:DEV_LSB] == DELAY_TAG);
    endfunction

    // Counter preload giving exactly N cycles in DELAY, with N=0 treated as one cycle
    function automatic logic [15:0] delay_load(input logic [31:0] word);
        logic [15:0] n;
        n = word[DLY_MSB:0];
        if (n == 16'd0) begin
            return 16'd0;
        end else begin
            return n - 16'd1;
        end
    endfunction

endpackage

// File: rtl/camera_cfg_seq_chk.sv
// Simulation checker: the write engine must never report tr_end as a transfer request begins.
module camera_cfg_seq_chk (
    input logic clock_i2c,
    input logic camera_rstn,
    input logic start,
    input logic tr_end
);

    property p_no_stale_tr_end;
        @(posedge clock_i2c) disable iff (!camera_rstn) $rose(start) |-> !tr_end;
    endproperty

    a_no_stale_tr_end: assert property (p_no_stale_tr_end);

endmodule

// File: rtl/camera_cfg_seq_wait_cnt.sv
// Loadable down-counter with zero flag, shared by the power-up wait and delay entries.
module cfg_wait_cnt #(
    parameter int unsigned W       = 32'd16,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clock_i2c,
    input  logic         camera_rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count down to zero and park there until the next load
    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            cnt_r <= RST_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/camera_cfg_seq.sv
// Camera register-table sequencer driving the i2c_com write engine.
// Define CAMERA_CFG_RETRY_EN to re-attempt NACKed entries up to MAX_RETRY times.
module camera_cfg_seq
    import camera_cfg_pkg::*;
#(
    parameter int unsigned REG_NUM   = 32'd200,
    parameter int unsigned IDX_W     = 32'd8,
    parameter int unsigned PWR_DLY   = PWR_DLY_DEF,
    parameter int unsigned MAX_RETRY = 32'd3
) (
    input  logic             clock_i2c,
    input  logic             camera_rstn,
    input  logic             cfg_go,
    output logic [IDX_W-1:0] lut_index,
    input  logic [31:0]      lut_data,
    output logic [31:0]      i2c_data,
    output logic             start,
    input  logic             tr_end,
    input  logic             ack,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_NUM - 32'd1);

    if ((REG_NUM > (32'd1 << IDX_W)) || (MAX_RETRY > 32'd15)) begin : g_param_check
        $error("camera_cfg_seq: parameter out of range");
    end

    cfg_state_t  state_r;
    cfg_state_t  state_s;
    cfg_state_t  adv_state_s;
    logic        load_ph_r;
    logic        advance_s;
    logic        fail_s;
    logic        wait_load_s;
    logic [15:0] wait_val_s;
    logic        wait_zero_s;
    logic        go_s;

    assign go_s        = (state_r == ST_DONE) && cfg_go;
    assign adv_state_s = (lut_index == LAST_IDX) ? ST_DONE : ST_FETCH;

`ifdef CAMERA_CFG_RETRY_EN
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 32'd2);
    logic [RTY_W-1:0] retry_cnt_r;

    // Re-attempts of the current entry; cleared whenever the table advances
    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            retry_cnt_r <= {RTY_W{1'b0}};
        end else if (advance_s) begin
            retry_cnt_r <= {RTY_W{1'b0}};
        end else if ((state_r == ST_CHECK) && (state_s == ST_LOAD)) begin
            retry_cnt_r <= retry_cnt_r + {{(RTY_W-1){1'b0}}, 1'b1};
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end
`endif

    // Next-state decode, plus table advance and failure strobes
    always_comb begin
        state_s     = state_r;
        advance_s   = 1'b0;
        fail_s      = 1'b0;
        wait_load_s = 1'b0;
        wait_val_s  = delay_load(lut_data);
        case (state_r)
            ST_PWR_WAIT: begin
                if (wait_zero_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_PWR_WAIT;
                end
            end
            ST_FETCH: begin
                if (is_delay_entry(lut_data)) begin
                    state_s     = ST_DELAY;
                    wait_load_s = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_ph_r) begin
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_XFER: begin
                if (tr_end) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_CHECK: begin
                if (!ack) begin
                    advance_s = 1'b1;
                    state_s   = adv_state_s;
                end
`ifdef CAMERA_CFG_RETRY_EN
                else if (retry_cnt_r < RTY_W'(MAX_RETRY)) begin
                    state_s = ST_LOAD;
                end
`endif
                else begin
                    fail_s    = 1'b1;
                    advance_s = 1'b1;
                    state_s   = adv_state_s;
                end
            end
            ST_DELAY: begin
                if (wait_zero_s) begin
                    advance_s = 1'b1;
                    state_s   = adv_state_s;
                end else begin
                    state_s = ST_DELAY;
                end
            end
            ST_DONE: begin
                if (cfg_go) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_PWR_WAIT;
            end
        endcase
    end

    cfg_wait_cnt #(
        .W       (32'd16),
        .RST_VAL (16'(PWR_DLY - 32'd1))
    ) u_wait_cnt (
        .clock_i2c   (clock_i2c),
        .camera_rstn (camera_rstn),
        .load        (wait_load_s),
        .load_val    (wait_val_s),
        .zero        (wait_zero_s)
    );

    // State and all outputs are registered from the next-state decode
    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state_r   <= ST_PWR_WAIT;
            load_ph_r <= 1'b0;
            lut_index <= {IDX_W{1'b0}};
            i2c_data  <= 32'h0000_0000;
            start     <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_index <= {IDX_W{1'b0}};
        end else begin
            state_r   <= state_s;
            load_ph_r <= (state_r == ST_LOAD) && !load_ph_r;
            start     <= (state_s == ST_XFER) || (state_s == ST_CHECK);
            cfg_busy  <= (state_s != ST_DONE);
            cfg_done  <= (state_s == ST_DONE);

            if ((state_r == ST_FETCH) && !is_delay_entry(lut_data)) begin
                i2c_data <= lut_data;
            end else begin
                i2c_data <= i2c_data;
            end

            if (go_s) begin
                lut_index <= {IDX_W{1'b0}};
            end else if (advance_s && (lut_index != LAST_IDX)) begin
                lut_index <= lut_index + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                lut_index <= lut_index;
            end

            // Only the first failure since reset or restart records its index
            if (go_s) begin
                cfg_err   <= 1'b0;
                err_index <= {IDX_W{1'b0}};
            end else if (fail_s) begin
                cfg_err   <= 1'b1;
                err_index <= cfg_err ? err_index : lut_index;
            end else begin
                cfg_err   <= cfg_err;
                err_index <= err_index;
            end
        end
    end

endmodule
